// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: active-low glyphs {dp,g,f,e,d,c,b,a}
// and the all-off codes for segments and digit enables.
package seg_pkg;

   typedef logic [7:0] seg_t;

   localparam seg_t SEG_0   = 8'hC0;
   localparam seg_t SEG_1   = 8'hF9;
   localparam seg_t SEG_2   = 8'hA4;
   localparam seg_t SEG_3   = 8'hB0;
   localparam seg_t SEG_4   = 8'h99;
   localparam seg_t SEG_5   = 8'h92;
   localparam seg_t SEG_6   = 8'h82;
   localparam seg_t SEG_7   = 8'hF8;
   localparam seg_t SEG_8   = 8'h80;
   localparam seg_t SEG_9   = 8'h90;
   localparam seg_t SEG_A   = 8'h88;
   localparam seg_t SEG_B   = 8'h83;
   localparam seg_t SEG_C   = 8'hC6;
   localparam seg_t SEG_D   = 8'hA1;
   localparam seg_t SEG_E   = 8'h86;
   localparam seg_t SEG_F   = 8'h8E;

   localparam seg_t       SEG_OFF = 8'hFF;
   localparam logic [7:0] DIG_OFF = 8'hFF;

endpackage

// File: rtl/seg_display_driver_hex_to_seg.sv
// Combinational nibble-to-glyph decoder (hex, lowercase b/d, dp off).
// Shared by the display blocks.
module hex_to_seg
   import seg_pkg::*;
(
   input  logic [3:0] nib_i,
   output seg_t       seg_o
);

   // Glyph lookup
   always_comb begin
      seg_o = SEG_OFF;
      case (nib_i)
         4'h0:    seg_o = SEG_0;
         4'h1:    seg_o = SEG_1;
         4'h2:    seg_o = SEG_2;
         4'h3:    seg_o = SEG_3;
         4'h4:    seg_o = SEG_4;
         4'h5:    seg_o = SEG_5;
         4'h6:    seg_o = SEG_6;
         4'h7:    seg_o = SEG_7;
         4'h8:    seg_o = SEG_8;
         4'h9:    seg_o = SEG_9;
         4'hA:    seg_o = SEG_A;
         4'hB:    seg_o = SEG_B;
         4'hC:    seg_o = SEG_C;
         4'hD:    seg_o = SEG_D;
         4'hE:    seg_o = SEG_E;
         4'hF:    seg_o = SEG_F;
         default: seg_o = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/seg_display_driver.sv
// Eight-digit multiplexed hex display driver. CPU writes land in a pending
// register that is copied to the displayed register only at a frame boundary.
module seg_display_driver
   import seg_pkg::*;
#(
   parameter int SCAN_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        we,
   input  logic [3:0]  wmask,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic [7:0]  dig_en,
   output logic [7:0]  seg
);

   localparam int             CNT_W    = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

   logic [31:0]      pending_q, pending_d;
   logic [31:0]      shown_q,   shown_d;
   logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
   logic [2:0]       dig_idx_q, dig_idx_d;
   logic [7:0]       dig_en_q, dig_en_d;
   seg_t             seg_q, seg_d;

   logic             tick_s;
   logic             frame_s;
   logic [3:0]       nib_s;
   seg_t             glyph_s;

   hex_to_seg u_hex_to_seg (
      .nib_i (nib_s),
      .seg_o (glyph_s)
   );

   // Byte-masked store into the pending register
   always_comb begin
      pending_d = pending_q;
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (wmask[i]) begin
               pending_d[8*i +: 8] = wdata[8*i +: 8];
            end else begin
               pending_d[8*i +: 8] = pending_q[8*i +: 8];
            end
         end
      end else begin
         pending_d = pending_q;
      end
   end

   // Scan timing, frame commit and output decode
   always_comb begin
      tick_s  = (scan_cnt_q == CNT_LAST);
      frame_s = tick_s && (dig_idx_q == 3'd7);

      if (tick_s) begin
         scan_cnt_d = {CNT_W{1'b0}};
         dig_idx_d  = dig_idx_q + 3'd1;
      end else begin
         scan_cnt_d = scan_cnt_q + CNT_W'(1);
         dig_idx_d  = dig_idx_q;
      end

      // Commit uses pending before any same-cycle write lands.
      if (frame_s) begin
         shown_d = pending_q;
      end else begin
         shown_d = shown_q;
      end

      nib_s    = shown_q[{dig_idx_q, 2'b00} +: 4];
      dig_en_d = ~(8'b0000_0001 << dig_idx_q);
      seg_d    = glyph_s;
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q  <= 32'h0000_0000;
         shown_q    <= 32'h0000_0000;
         scan_cnt_q <= {CNT_W{1'b0}};
         dig_idx_q  <= 3'd0;
         dig_en_q   <= DIG_OFF;
         seg_q      <= SEG_OFF;
      end else begin
         pending_q  <= pending_d;
         shown_q    <= shown_d;
         scan_cnt_q <= scan_cnt_d;
         dig_idx_q  <= dig_idx_d;
         dig_en_q   <= dig_en_d;
         seg_q      <= seg_d;
      end
   end

   assign rdata  = pending_q;
   assign dig_en = dig_en_q;
   assign seg    = seg_q;

endmodule

// File: tb/tb_seg_display_driver.sv
// Self-checking bench for seg_display_driver with SCAN_DIV=4: per-cycle scan
// checks against a time-based model, and a queue of commits for the display.
module tb_seg_display_driver;

   localparam int SCAN_DIV = 4;

   logic        clk;
   logic        rst_n;
   logic        we;
   logic [3:0]  wmask;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [7:0]  dig_en;
   logic [7:0]  seg;

   seg_display_driver #(.SCAN_DIV(SCAN_DIV)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (we),
      .wmask  (wmask),
      .wdata  (wdata),
      .rdata  (rdata),
      .dig_en (dig_en),
      .seg    (seg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          vis;
      logic [31:0] val;
   } sb_t;

   typedef struct {
      logic        w;
      logic [3:0]  m;
      logic [31:0] d;
      logic [31:0] exp_rd;
   } vec_t;

   logic [7:0] glyph_tb [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   sb_t         sb_q[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc    = -1;
   bit          chk_en = 1'b0;
   logic [31:0] exp_pend  = 32'h0;
   logic [31:0] shown_mdl = 32'h0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // One clock; afterwards compare the scan outputs against the time-based model.
   task automatic step();
      int          d;
      logic [7:0]  exp_en;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (chk_en) begin
         while (sb_q.size() > 0 && sb_q[0].vis <= cyc) begin
            shown_mdl = sb_q[0].val;
            void'(sb_q.pop_front());
         end
         d      = (cyc / SCAN_DIV) % 8;
         exp_en = 8'hFF;
         exp_en[d] = 1'b0;
         check($sformatf("dig_en@%0d", cyc), {24'h0, dig_en}, {24'h0, exp_en});
         check($sformatf("seg@%0d", cyc), {24'h0, seg},
               {24'h0, glyph_tb[shown_mdl[4*d +: 4]]});
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Drive one bus cycle; the expected commit goes on the scoreboard.
   task automatic apply(input logic w, input logic [3:0] m, input logic [31:0] d,
                        input logic [31:0] exp_rd, input string nm);
      int  k;
      sb_t e;
      k = cyc + 1;
      if (w) begin
         for (int i = 0; i < 4; i++) begin
            if (m[i]) exp_pend[8*i +: 8] = d[8*i +: 8];
         end
      end
      e.vis = ((k + 1) / (8 * SCAN_DIV)) * (8 * SCAN_DIV) + 8 * SCAN_DIV;
      e.val = exp_pend;
      sb_q.push_back(e);
      we = w; wmask = m; wdata = d;
      step();
      we = 1'b0; wmask = 4'h0; wdata = 32'h0;
      check(nm, rdata, exp_rd);
   endtask

   task automatic release_reset();
      rst_n     = 1'b1;
      cyc       = -1;
      exp_pend  = 32'h0;
      shown_mdl = 32'h0;
      sb_q.delete();
      chk_en    = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vecs [5];
      vecs[0] = '{w: 1'b1, m: 4'hF,    d: 32'h1234_ABCD, exp_rd: 32'h1234_ABCD};
      vecs[1] = '{w: 1'b1, m: 4'b0010, d: 32'hFFFF_55FF, exp_rd: 32'h1234_55CD};
      vecs[2] = '{w: 1'b1, m: 4'h0,    d: 32'hDEAD_BEEF, exp_rd: 32'h1234_55CD};
      vecs[3] = '{w: 1'b0, m: 4'hF,    d: 32'h0BAD_F00D, exp_rd: 32'h1234_55CD};
      vecs[4] = '{w: 1'b1, m: 4'b1001, d: 32'hE0FF_FF07, exp_rd: 32'hE034_5507};

      rst_n = 1'b0; we = 1'b0; wmask = 4'h0; wdata = 32'h0;

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_dig_en", {24'h0, dig_en}, 32'hFF);
         check("rst_seg",    {24'h0, seg},    32'hFF);
         check("rst_rdata",  rdata,           32'h0);
      end

      release_reset();
      run(70);

      // Table: full write, byte masks, masked no-op and idle bus.
      for (int i = 0; i < 5; i++) begin
         apply(vecs[i].w, vecs[i].m, vecs[i].d, vecs[i].exp_rd, $sformatf("rdata_vec%0d", i));
         run(45);
      end

      // Write landing exactly on the 7->0 tick.
      while (((cyc + 1) % (8 * SCAN_DIV)) != (8 * SCAN_DIV - 1)) step();
      apply(1'b1, 4'hF, 32'h0000_0008, 32'h0000_0008, "rdata_coincident");
      run(70);

      // Glyph sweep, one full displayed frame per value.
      for (int n = 0; n < 16; n++) begin
         while (((cyc + 1) % (8 * SCAN_DIV)) != 0) step();
         apply(1'b1, 4'hF, 32'(n), 32'(n), $sformatf("rdata_sweep%0d", n));
         run(16 * SCAN_DIV);
      end

      // Asynchronous reset while digit 5 is lit.
      while (!(((cyc / SCAN_DIV) % 8 == 5) && (cyc % SCAN_DIV == 1))) step();
      check("pre_reset_dig5", {24'h0, dig_en}, 32'hDF);
      chk_en = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_dig_en", {24'h0, dig_en}, 32'hFF);
      check("async_seg",    {24'h0, seg},    32'hFF);
      check("async_rdata",  rdata,           32'h0);
      @(negedge clk);
      @(negedge clk);
      check("held_dig_en", {24'h0, dig_en}, 32'hFF);
      release_reset();
      run(40);
      check("post_reset_rdata", rdata, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
